// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared types and constants for the LSU AXI4-Lite master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, AXI response codes (plus the local timeout code),
// and bit positions of the start_write/start_read controls in i_ctrl.
package axi_lite_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR      = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_ADDR = 3'd3,
      ST_RD_DATA = 3'd4
   } state_e;

   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam logic [1:0] RESP_EXOKAY  = 2'b01;
   localparam logic [1:0] RESP_SLVERR  = 2'b10;
   localparam logic [1:0] RESP_DECERR  = 2'b11;
   // Aborted handshakes reuse the DECERR encoding so the core sees one error class.
   localparam logic [1:0] RESP_TIMEOUT = 2'b11;

   localparam int CTRL_WR_BIT = 0;
   localparam int CTRL_RD_BIT = 1;

endpackage

// File: rtl/ctrl_edge_detect.sv
// ctrl_edge_detect: per-bit rising-edge detector for software-held control levels.
// Latency: combinational pulse in the cycle the level first reads high.
// Backpressure: none; edges are reported unconditionally.
// Ports: i_clk, i_rst (async, active-high), i_lvl level inputs, o_rise one-cycle pulses.
module ctrl_edge_detect #(
   parameter int W = 2
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_lvl,
   output logic [W-1:0] o_rise
);

   logic [W-1:0] lvl_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lvl_q <= '0;
      end else begin
         lvl_q <= i_lvl;
      end
   end

   assign o_rise = i_lvl & ~lvl_q;

endmodule

// File: rtl/lsu_axi_master.sv
// lsu_axi_master: turns LSU register starts into single AXI4-Lite write/read transactions.
// Latency: VALID one cycle after the start edge; done pulses one cycle after the last handshake.
// Backpressure: VALIDs held until READY; starts arriving while busy are dropped and flagged.
// Ports: i_addr/i_wdata/i_wstrb/i_sel/i_ctrl from the register bank; AW/W/B/AR/R master
// channels; o_rdata/o_resp/o_busy/o_done/o_drop status back to the core.
// Build option: AXI_MASTER_TIMEOUT_EN adds a per-state handshake timeout (TIMEOUT_CYCLES).
module lsu_axi_master
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [3:0]        i_wstrb,
   input  logic              i_sel,
   input  logic [1:0]        i_ctrl,
   output logic [ADDR_W-1:0] o_awaddr,
   output logic              o_awvalid,
   input  logic              i_awready,
   output logic [DATA_W-1:0] o_wdata,
   output logic [3:0]        o_wstrb,
   output logic              o_wvalid,
   input  logic              i_wready,
   input  logic [1:0]        i_bresp,
   input  logic              i_bvalid,
   output logic              o_bready,
   output logic [ADDR_W-1:0] o_araddr,
   output logic              o_arvalid,
   input  logic              i_arready,
   input  logic [DATA_W-1:0] i_rdata,
   input  logic [1:0]        i_rresp,
   input  logic              i_rvalid,
   output logic              o_rready,
   output logic [DATA_W-1:0] o_rdata,
   output logic [1:0]        o_resp,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_drop
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("lsu_axi_master: TIMEOUT_CYCLES must be at least 2");
   end

   state_e            state_q, state_d;
   logic              pend_q, pend_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic              arvalid_q, arvalid_d, rready_q, rready_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        resp_q, resp_d;
   logic              done_q, done_d, drop_q, drop_d;

   logic [1:0] rise;
   logic       wr_start, rd_start, busy, tmo_hit;

   ctrl_edge_detect #(.W(2)) u_edge (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_lvl  (i_ctrl),
      .o_rise (rise)
   );

   assign wr_start = rise[CTRL_WR_BIT] & i_sel;
   assign rd_start = rise[CTRL_RD_BIT] & i_sel;
   // A queued read still counts as busy even though the FSM sits in IDLE for a cycle.
   assign busy     = (state_q != ST_IDLE) | pend_q;

`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] cnt_q;

   // Counts cycles spent in the current non-IDLE state; restarts on every state change.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else if ((state_d != state_q) || (state_q == ST_IDLE)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tmo_hit = (state_q != ST_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      done_d    = 1'b0;
      drop_d    = drop_q;

      // Any qualified start either is accepted (clears the flag) or is discarded (sets it).
      if (wr_start | rd_start) begin
         drop_d = busy;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (pend_q) begin
               // Read half of a simultaneous start; addr_q still holds its address.
               pend_d    = 1'b0;
               arvalid_d = 1'b1;
               state_d   = ST_RD_ADDR;
            end else if (wr_start) begin
               addr_d    = i_addr;
               wdata_d   = i_wdata;
               wstrb_d   = i_wstrb;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               pend_d    = rd_start;
               state_d   = ST_WR;
            end else if (rd_start) begin
               addr_d    = i_addr;
               arvalid_d = 1'b1;
               state_d   = ST_RD_ADDR;
            end
         end
         ST_WR: begin
            awvalid_d = awvalid_q & ~i_awready;
            wvalid_d  = wvalid_q & ~i_wready;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            if (bready_q && i_bvalid) begin
               resp_d   = i_bresp;
               done_d   = 1'b1;
               bready_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         ST_RD_ADDR: begin
            if (i_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            if (rready_q && i_rvalid) begin
               rdata_d  = i_rdata;
               resp_d   = i_rresp;
               done_d   = 1'b1;
               rready_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort only when the pending handshake did not complete in this same cycle.
      if (tmo_hit && (state_d == state_q)) begin
         awvalid_d = 1'b0;
         wvalid_d  = 1'b0;
         bready_d  = 1'b0;
         arvalid_d = 1'b0;
         rready_d  = 1'b0;
         pend_d    = 1'b0;
         resp_d    = RESP_TIMEOUT;
         done_d    = 1'b1;
         state_d   = ST_IDLE;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         pend_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         rdata_q   <= '0;
         resp_q    <= RESP_OKAY;
         done_q    <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         done_q    <= done_d;
         drop_q    <= drop_d;
      end
   end

   assign o_awaddr  = addr_q;
   assign o_awvalid = awvalid_q;
   assign o_wdata   = wdata_q;
   assign o_wstrb   = wstrb_q;
   assign o_wvalid  = wvalid_q;
   assign o_bready  = bready_q;
   assign o_araddr  = addr_q;
   assign o_arvalid = arvalid_q;
   assign o_rready  = rready_q;
   assign o_rdata   = rdata_q;
   assign o_resp    = resp_q;
   assign o_busy    = busy;
   assign o_done    = done_q;
   assign o_drop    = drop_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// tb_lsu_axi_master: scoreboard bench for lsu_axi_master with a delay-programmable AXI-Lite slave.
// Expected channel payloads and completion results are queued at issue time and popped by a
// separate slave/monitor process whenever the DUT handshakes or pulses o_done.
module tb_lsu_axi_master;

   logic        clk;
   logic        rst;
   logic [31:0] i_addr, i_wdata, i_rdata;
   logic [3:0]  i_wstrb;
   logic        i_sel;
   logic [1:0]  i_ctrl, i_bresp, i_rresp;
   logic        i_awready, i_wready, i_bvalid, i_arready, i_rvalid;
   logic [31:0] o_awaddr, o_wdata, o_araddr, o_rdata;
   logic [3:0]  o_wstrb;
   logic [1:0]  o_resp;
   logic        o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_busy, o_done, o_drop;

   typedef struct { logic [1:0] resp; logic [31:0] rdata; } done_t;
   typedef struct { logic [31:0] d; logic [3:0] s; } w_t;
   typedef struct { logic [1:0] resp; logic [31:0] data; } rsp_t;

   logic [31:0] aw_exp_q[$];
   w_t          w_exp_q[$];
   logic [31:0] ar_exp_q[$];
   done_t       done_exp_q[$];
   logic [1:0]  b_rsp_q[$];
   rsp_t        r_rsp_q[$];

   int errors = 0;
   int checks = 0;
   int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic [31:0] model_rdata = 32'h0;

   lsu_axi_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
      .i_sel(i_sel), .i_ctrl(i_ctrl),
      .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
      .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
      .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
      .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
      .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
      .o_rdata(o_rdata), .o_resp(o_resp), .o_busy(o_busy), .o_done(o_done), .o_drop(o_drop)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave + monitor. Inputs change at negedge; #1 later the handshakes that the next
   // posedge will perform are evaluated against the scoreboard queues.
   initial begin : slave_monitor
      int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
      bit aw_hs, w_hs, b_pend, r_pend, aw_stall, w_stall, ar_stall;
      logic [31:0] aw_prev, ar_prev, wd_prev;
      logic [3:0]  ws_prev;
      done_t de;
      w_t    we;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_hs = 0; w_hs = 0; b_pend = 0; r_pend = 0; aw_stall = 0; w_stall = 0; ar_stall = 0;
      aw_prev = 0; ar_prev = 0; wd_prev = 0; ws_prev = 0;
      i_awready = 0; i_wready = 0; i_arready = 0; i_bvalid = 0; i_bresp = 0;
      i_rvalid = 0; i_rdata = 0; i_rresp = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            aw_hs = 0; w_hs = 0; b_pend = 0; r_pend = 0;
            aw_stall = 0; w_stall = 0; ar_stall = 0;
            i_awready = 0; i_wready = 0; i_arready = 0; i_bvalid = 0; i_rvalid = 0;
            aw_exp_q.delete(); w_exp_q.delete(); ar_exp_q.delete();
            done_exp_q.delete(); b_rsp_q.delete(); r_rsp_q.delete();
            continue;
         end
         i_awready = o_awvalid && (aw_cnt >= aw_dly);
         i_wready  = o_wvalid && (w_cnt >= w_dly);
         i_arready = o_arvalid && (ar_cnt >= ar_dly);
         i_bvalid  = b_pend && (b_cnt >= b_dly);
         i_bresp   = (b_rsp_q.size() > 0) ? b_rsp_q[0] : 2'b00;
         i_rvalid  = r_pend && (r_cnt >= r_dly);
         if (r_rsp_q.size() > 0) begin
            i_rresp = r_rsp_q[0].resp;
            i_rdata = r_rsp_q[0].data;
         end
         #1;
         // A stalled VALID must still be up with unchanged payload one cycle later.
         if (aw_stall) check("aw_hold", {o_awvalid, o_awaddr}, {1'b1, aw_prev});
         if (w_stall)  check("w_hold", {o_wvalid, o_wstrb, o_wdata}, {1'b1, ws_prev, wd_prev});
         if (ar_stall) check("ar_hold", {o_arvalid, o_araddr}, {1'b1, ar_prev});
         aw_stall = o_awvalid && !i_awready; aw_prev = o_awaddr;
         w_stall  = o_wvalid && !i_wready;   wd_prev = o_wdata; ws_prev = o_wstrb;
         ar_stall = o_arvalid && !i_arready; ar_prev = o_araddr;

         if (o_awvalid && i_awready) begin
            check("aw_expected", aw_exp_q.size() != 0, 1);
            if (aw_exp_q.size() != 0) check("awaddr", o_awaddr, aw_exp_q.pop_front());
            aw_cnt = 0; aw_hs = 1;
         end else if (o_awvalid) aw_cnt++;
         if (o_wvalid && i_wready) begin
            check("w_expected", w_exp_q.size() != 0, 1);
            if (w_exp_q.size() != 0) begin
               we = w_exp_q.pop_front();
               check("wdata_wstrb", {o_wstrb, o_wdata}, {we.s, we.d});
            end
            w_cnt = 0; w_hs = 1;
         end else if (o_wvalid) w_cnt++;
         if (aw_hs && w_hs) begin
            b_pend = 1; b_cnt = 0; aw_hs = 0; w_hs = 0;
         end
         if (i_bvalid && o_bready) begin
            if (b_rsp_q.size() != 0) void'(b_rsp_q.pop_front());
            b_pend = 0;
         end else if (b_pend) b_cnt++;

         if (o_arvalid && i_arready) begin
            check("ar_expected", ar_exp_q.size() != 0, 1);
            if (ar_exp_q.size() != 0) check("araddr", o_araddr, ar_exp_q.pop_front());
            ar_cnt = 0; r_pend = 1; r_cnt = 0;
         end else if (o_arvalid) ar_cnt++;
         if (i_rvalid && o_rready) begin
            if (r_rsp_q.size() != 0) void'(r_rsp_q.pop_front());
            r_pend = 0;
         end else if (r_pend) r_cnt++;

         if (o_done) begin
            check("done_expected", done_exp_q.size() != 0, 1);
            if (done_exp_q.size() != 0) begin
               de = done_exp_q.pop_front();
               check("done_resp", o_resp, de.resp);
               check("done_rdata", o_rdata, de.rdata);
            end
            // A finished or aborted transaction leaves no response outstanding.
            b_pend = 0; r_pend = 0;
         end
      end
   end

   task automatic pulse_ctrl(input logic [1:0] bits);
      @(negedge clk); i_ctrl = bits;
      @(negedge clk); i_ctrl = 2'b00;
   endtask

   // Queue what the transaction must produce, then raise the start level(s) for one cycle.
   task automatic issue(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] bresp, input logic [1:0] rresp,
                        input logic [31:0] rdat);
      done_t de;
      if (wr) begin
         aw_exp_q.push_back(a);
         w_exp_q.push_back(w_t'{d, s});
         b_rsp_q.push_back(bresp);
         de = '{bresp, model_rdata};
         done_exp_q.push_back(de);
      end
      if (rd) begin
         ar_exp_q.push_back(a);
         r_rsp_q.push_back(rsp_t'{rresp, rdat});
         model_rdata = rdat;
         de = '{rresp, rdat};
         done_exp_q.push_back(de);
      end
      i_addr = a; i_wdata = d; i_wstrb = s; i_sel = 1'b1;
      pulse_ctrl({rd, wr});
      if (wr) check("awvalid_next_cycle", {o_awvalid, o_wvalid}, 2'b11);
      else    check("arvalid_next_cycle", o_arvalid, 1);
      check("busy_after_start", o_busy, 1);
      // Scramble the register inputs: the master must work from its latched copy.
      i_addr = $urandom; i_wdata = $urandom; i_wstrb = 4'($urandom);
   endtask

   task automatic wait_all(input string name);
      int n;
      bit gap;
      n = 0; gap = 0;
      while (done_exp_q.size() != 0 && n < 300) begin
         @(negedge clk); n++;
         if (done_exp_q.size() != 0 && !o_busy && !o_done) gap = 1;
      end
      check({name, "_all_done"}, done_exp_q.size(), 0);
      check({name, "_busy_continuous"}, gap, 0);
      check({name, "_no_leftover_addr"}, aw_exp_q.size() + w_exp_q.size() + ar_exp_q.size(), 0);
      @(negedge clk);
      check({name, "_idle"}, o_busy, 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int n;
      int kind;
      rst = 1'b1; i_addr = 0; i_wdata = 0; i_wstrb = 0; i_sel = 0; i_ctrl = 0;
      repeat (3) @(negedge clk);
      check("rst_valids", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready}, 0);
      check("rst_status", {o_busy, o_done, o_drop, o_resp}, 0);
      check("rst_data", {o_rdata, o_awaddr}, 0);
      @(posedge clk); #2 rst = 1'b0;

      // Directed write, slave always ready.
      issue(1, 0, 32'h1000_0000, 32'h0000_00A5, 4'hF, 2'b00, 2'b00, 32'h0);
      wait_all("write_basic");
      check("write_basic_resp", o_resp, 2'b00);

      // Directed read with arready held off for three cycles.
      ar_dly = 3;
      issue(0, 1, 32'h1000_0004, 32'h0, 4'h0, 2'b00, 2'b00, 32'h0000_0041);
      wait_all("read_delayed");
      check("read_rdata", o_rdata, 32'h0000_0041);
      ar_dly = 0;

      // Both starts in one cycle: write, then the queued read, busy never dropping.
      issue(1, 1, 32'h2000_0010, 32'hDEAD_BEEF, 4'h3, 2'b10, 2'b01, 32'h1234_5678);
      wait_all("both_starts");

      // W accepted five cycles after AW.
      w_dly = 5;
      issue(1, 0, 32'h3000_0020, 32'hCAFE_F00D, 4'hC, 2'b00, 2'b00, 32'h0);
      wait_all("w_late");
      w_dly = 0;

      // Start edge while busy is discarded and flagged; next accepted start clears the flag.
      b_dly = 8;
      issue(1, 0, 32'h4000_0000, 32'h0000_0011, 4'h1, 2'b00, 2'b00, 32'h0);
      pulse_ctrl(2'b10);
      check("drop_set", o_drop, 1);
      wait_all("drop_write");
      check("drop_sticky", o_drop, 1);
      b_dly = 0;
      issue(0, 1, 32'h4000_0004, 32'h0, 4'h0, 2'b00, 2'b00, 32'h0000_0099);
      check("drop_cleared", o_drop, 0);
      wait_all("drop_read");

      // Edge with i_sel low starts nothing.
      i_sel = 1'b0;
      pulse_ctrl(2'b01);
      repeat (5) @(negedge clk);
      check("sel_low_ignored", {o_busy, o_awvalid, o_wvalid, o_arvalid, o_drop}, 0);

      // Randomised traffic with random slave latencies and responses.
      for (int t = 0; t < 24; t++) begin
         aw_dly = $urandom_range(0, 4); w_dly = $urandom_range(0, 4); b_dly = $urandom_range(0, 4);
         ar_dly = $urandom_range(0, 4); r_dly = $urandom_range(0, 4);
         kind = $urandom_range(0, 2);
         issue(kind != 1, kind != 0, $urandom, $urandom, 4'($urandom), 2'($urandom),
               2'($urandom), $urandom);
         wait_all("random");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;

`ifdef AXI_MASTER_TIMEOUT_EN
      // B never arrives: after sixteen cycles in WR_RESP the master aborts with 2'b11.
      b_dly = 100000;
      issue(1, 0, 32'h5000_0000, 32'h0000_0077, 4'hF, 2'b11, 2'b00, 32'h0);
      n = 0;
      while (!o_done && n < 100) begin
         @(negedge clk); n++;
      end
      check("timeout_latency", n, 17);
      wait_all("timeout");
      check("timeout_resp", o_resp, 2'b11);
      b_rsp_q.delete();
      b_dly = 0;
`endif

      // Reset while the read is waiting for R data: everything returns to zero.
      r_dly = 10;
      issue(0, 1, 32'h6000_0000, 32'h0, 4'h0, 2'b00, 2'b00, 32'h0000_ABCD);
      repeat (4) @(negedge clk);
      check("midread_rready", o_rready, 1);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      check("midreset_valids", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready}, 0);
      check("midreset_status", {o_busy, o_done, o_drop, o_resp}, 0);
      check("midreset_rdata", o_rdata, 0);
      model_rdata = 32'h0;
      @(posedge clk); #2 rst = 1'b0;
      r_dly = 0;
      issue(1, 0, 32'h7000_0000, 32'h0000_0055, 4'hF, 2'b01, 2'b00, 32'h0);
      wait_all("after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
